grf_sb: RTL and testbench
=========================

Name: grf_sb

Overview:
- Parametrised general register file for the pipelined core.
- Generalises the fixed 2-read/1-write GRF to NUM_RD read ports and configurable width/depth.
- Adds write-through bypass and a per-register pending-write scoreboard, so the hazard unit can derive freeze directly from rd_busy.
- Sits in the D stage: read ports serve the decode operand fetch; the write port is driven by the W stage.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register address width; depth = 2**ADDR_W.
- NUM_RD, 2: number of independent read ports (1..4).
- MAX_INFLIGHT, 3: maximum outstanding writes tracked per register. Counter width CNT_W = clog2(MAX_INFLIGHT+1).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- we, input, 1: W-stage write enable.
- waddr, input, ADDR_W: write address.
- wdata, input, DATA_W: write data.
- rd_addr, input, NUM_RD*ADDR_W: packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data, output, NUM_RD*DATA_W: packed read data, combinational.
- rd_busy, output, NUM_RD: port i's register still has a pending write after this cycle's writeback.
- issue_valid, input, 1: an instruction leaving D will write issue_addr later.
- issue_addr, input, ADDR_W: destination register of the issued instruction.
- flush, input, 1: synchronous clear of all pending counters; register data is untouched.
- err_underflow, output, 1: sticky; set when a write hits a register whose counter is 0.
- err_overflow, output, 1: sticky; set when an issue hits a register whose counter is MAX_INFLIGHT.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers = 0, all counters = 0, both err flags = 0.
  - rd_busy = 0 while in reset, since all counters are 0.
- Register 0:
  - always reads 0 and is never busy.
  - writes to it are ignored; issues to it are ignored.
  - err flags never set for address 0.
- Write: on a clock edge with we=1 and waddr!=0, reg[waddr] <= wdata.
- Read, per port i (combinational):
  - rd_addr_i==0 -> rd_data_i = 0.
  - otherwise, if we && waddr==rd_addr_i -> rd_data_i = wdata (write-through bypass, same cycle).
  - otherwise rd_data_i = reg[rd_addr_i].
- Counter update per register r!=0, evaluated each edge:
  - flush=1 -> cnt[r] <= 0. flush has priority over issue and write in the same cycle. The data write itself still happens.
  - inc = issue_valid && issue_addr==r. dec = we && waddr==r.
  - inc && dec -> counter unchanged (net zero), including at 0 and at MAX.
  - inc only: if cnt==MAX_INFLIGHT, hold and set err_overflow; else cnt+1.
  - dec only: if cnt==0, hold at 0 and set err_underflow (write still performed); else cnt-1.
- rd_busy_i:
  - = (eff_cnt != 0), where eff_cnt = cnt[rd_addr_i] - (we && waddr==rd_addr_i && cnt!=0).
  - So the final outstanding write, bypassed this cycle, does not stall.
  - A same-cycle issue to the same address does NOT make rd_busy high this cycle; it takes effect next cycle.
- Error flags are sticky until reset; flush does not clear them.
- Multiple read ports may hold the same address; each port resolves independently and identically.
- Latency:
  - data written at edge N is visible from reg at N+, and via bypass during cycle N.
  - counter changes at edge N are reflected in rd_busy from cycle N+1.

Decomposition:
- Shared package grf_pkg:
  - default DATA_W/ADDR_W.
  - clog2 function for CNT_W.
  - ZERO_REG constant (0).
- Sub-module sb_cnt:
  - one saturating up/down pending counter with inc, dec, clr inputs and ovf/udf pulse outputs.
  - instantiated 2**ADDR_W - 1 times in a generate loop.
- The top module holds the register array, read muxes with bypass, and the sticky error OR-reduction.

Test Plan:
- Reset then read: reset=0 for 2 cycles, release, rd_addr={5,0} -> rd_data={0,0}, rd_busy=0, errors 0. Assert reset mid-burst of writes -> all state 0 immediately, without a clock.
- Write/bypass: we=1, waddr=7, wdata=0xDEADBEEF, rd_addr0=7 in the same cycle -> rd_data0=0xDEADBEEF that cycle and after. Write to reg 0 with 0x1234 -> still reads 0.
- Scoreboard:
  - issue r3 twice (cycles 1,2) -> rd_busy for r3 high from cycle 2.
  - first write to r3 -> still busy.
  - second write to r3 -> rd_busy=0 in that same cycle, with rd_data = the bypassed wdata.
- Simultaneous issue+write on r9 with cnt=1 -> cnt stays 1, busy remains. Same with cnt=0 -> cnt 0, no err_underflow.
- Saturation (MAX_INFLIGHT=3): four issues to r4 -> cnt=3, err_overflow=1. Write to r10 with cnt=0 -> err_underflow=1, data still written.
- Flush: r2 cnt=2, r6 cnt=1, flush=1 with issue r2 and we to r6 in the same cycle:
  - next cycle all rd_busy=0, r6 holds new data.
  - error flags unchanged.
  - run with NUM_RD=4, all ports on r2.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared definitions for the parametrised general register file and its
// pending-write scoreboard.
package grf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  // Smallest width able to encode values 0 .. value-1.
  function automatic int clog2(input int value);
    int width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/grf_sb_if.sv
// Decode-stage register file bus: W-stage write port, operand read ports,
// issue/flush scoreboard controls and the sticky error flags.
interface grf_sb_if
  import grf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
);

  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     flush;
  logic                     err_underflow;
  logic                     err_overflow;

  modport master (
    output we, waddr, wdata, rd_addr, issue_valid, issue_addr, flush,
    input  rd_data, rd_busy, err_underflow, err_overflow
  );

  modport slave (
    input  we, waddr, wdata, rd_addr, issue_valid, issue_addr, flush,
    output rd_data, rd_busy, err_underflow, err_overflow
  );

endinterface

// File: rtl/sb_cnt.sv
// Saturating pending-write counter for one register; ovf/udf pulse when an
// unpaired issue or write would leave the range 0..MAX.
module sb_cnt #(
  parameter int MAX   = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             udf
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_nxt;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the ifs leaves a value unassigned and infers a latch.
  always_comb begin
    cnt_nxt = cnt;
    ovf     = 1'b0;
    udf     = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
    end else if (inc && !dec) begin
      if (cnt == MAX_C) ovf = 1'b1;
      else              cnt_nxt = cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) udf = 1'b1;
      else           cnt_nxt = cnt - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/grf_sb.sv
// General register file with NUM_RD bypassed read ports and a per-register
// pending-write scoreboard driving rd_busy for the hazard unit.
module grf_sb
  import grf_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int NUM_RD       = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input logic      clk,
  input logic      reset,
  grf_sb_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = clog2(MAX_INFLIGHT + 1);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]            regs [DEPTH];
  logic [DEPTH-1:0][CNT_W-1:0]  cnt;
  logic [DEPTH-1:0]             ovf_vec;
  logic [DEPTH-1:0]             udf_vec;
  logic                         err_ovf_q;
  logic                         err_udf_q;
  logic [NUM_RD*DATA_W-1:0]     rd_data_c;
  logic [NUM_RD-1:0]            rd_busy_c;

  // NOTE: the register array is reset because software may read any register
  // before writing it; a non-reset array would leave X in the datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else if (bus.we && bus.waddr != ZERO_A) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // Register 0 has no counter: it can never be busy or raise an error.
  assign cnt[0]     = '0;
  assign ovf_vec[0] = 1'b0;
  assign udf_vec[0] = 1'b0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_cnt
    sb_cnt #(.MAX(MAX_INFLIGHT), .CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (bus.issue_valid && bus.issue_addr == ADDR_W'(r)),
      .dec   (bus.we && bus.waddr == ADDR_W'(r)),
      .clr   (bus.flush),
      .cnt   (cnt[r]),
      .ovf   (ovf_vec[r]),
      .udf   (udf_vec[r])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_q | (|ovf_vec);
      err_udf_q <= err_udf_q | (|udf_vec);
    end
  end

  // The write landing this cycle is both bypassed and retired, so it neither
  // returns stale data nor stalls the reader.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] a;
      logic              hit;
      logic [CNT_W-1:0]  eff_cnt;
      a       = bus.rd_addr[i*ADDR_W +: ADDR_W];
      hit     = bus.we && bus.waddr == a;
      eff_cnt = cnt[a] - CNT_W'(hit && cnt[a] != '0);
      if (a == ZERO_A)  rd_data_c[i*DATA_W +: DATA_W] = '0;
      else if (hit)     rd_data_c[i*DATA_W +: DATA_W] = bus.wdata;
      else              rd_data_c[i*DATA_W +: DATA_W] = regs[a];
      rd_busy_c[i] = (a != ZERO_A) && (eff_cnt != '0);
    end
  end

  assign bus.rd_data       = rd_data_c;
  assign bus.rd_busy       = rd_busy_c;
  assign bus.err_overflow  = err_ovf_q;
  assign bus.err_underflow = err_udf_q;

endmodule

// File: tb/tb_grf_sb.sv
// Directed bench for grf_sb: an integer register/pending-count model checked
// every cycle, plus hand-computed expectations pinning the model.
module tb_grf_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 4;
  localparam int MAXI   = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  grf_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  grf_sb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else             n_pass++;
  endtask

  // Model: plain register contents and outstanding-write counts.
  int mreg [32] = '{default: 0};
  int mcnt [32] = '{default: 0};
  bit m_ovf = 0;
  bit m_udf = 0;

  always @(posedge clk or negedge reset) begin : model
    int ia, wa;
    if (!reset) begin
      for (int r = 0; r < 32; r++) begin mreg[r] = 0; mcnt[r] = 0; end
      m_ovf = 0;
      m_udf = 0;
    end else begin
      ia = bus.issue_valid ? int'(bus.issue_addr) : 0;
      wa = bus.we ? int'(bus.waddr) : 0;
      if (bus.flush) begin
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
      end else if (!(ia != 0 && ia == wa)) begin
        if (ia != 0) begin
          if (mcnt[ia] == MAXI) m_ovf = 1; else mcnt[ia]++;
        end
        if (wa != 0) begin
          if (mcnt[wa] == 0) m_udf = 1; else mcnt[wa]--;
        end
      end
      if (wa != 0) mreg[wa] = int'(bus.wdata);
    end
  end

  always @(negedge clk) begin : compare
    logic [NUM_RD-1:0] exp_busy;
    for (int i = 0; i < NUM_RD; i++) begin
      int a, pend;
      bit hit;
      logic [31:0] exp_data;
      a   = int'(bus.rd_addr[i*ADDR_W +: ADDR_W]);
      hit = bus.we && int'(bus.waddr) == a;
      if (a == 0)   exp_data = 0;
      else if (hit) exp_data = bus.wdata;
      else          exp_data = mreg[a];
      pend = mcnt[a] - ((hit && mcnt[a] > 0) ? 1 : 0);
      exp_busy[i] = (a != 0) && (pend > 0);
      check($sformatf("cyc rd_data[%0d]", i), 64'(bus.rd_data[i*DATA_W +: DATA_W]), 64'(exp_data));
    end
    check("cyc rd_busy", 64'(bus.rd_busy), 64'(exp_busy));
    check("cyc err_overflow", 64'(bus.err_overflow), 64'(m_ovf));
    check("cyc err_underflow", 64'(bus.err_underflow), 64'(m_udf));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0;
    bus.issue_valid = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic set_port(input int i, input int a);
    bus.rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  function automatic logic [31:0] port_data(input int i);
    return bus.rd_data[i*DATA_W +: DATA_W];
  endfunction

  initial begin
    bus.we = 0; bus.waddr = '0; bus.wdata = '0; bus.rd_addr = '0;
    bus.issue_valid = 0; bus.issue_addr = '0; bus.flush = 0;

    // Reset, then read.
    step(); step();
    check("in-reset rd_busy", 64'(bus.rd_busy), 64'h0);
    reset = 1'b1;
    set_port(0, 5); set_port(1, 0);
    #1;
    check("reset rd_data0", 64'(port_data(0)), 64'h0);
    check("reset rd_data1", 64'(port_data(1)), 64'h0);
    check("reset errs", 64'({bus.err_overflow, bus.err_underflow}), 64'h0);

    // Issue r7, then write it: final pending write is bypassed and not busy.
    step(); bus.issue_valid = 1; bus.issue_addr = 7; set_port(0, 7);
    step(); idle(); bus.we = 1; bus.waddr = 7; bus.wdata = 32'hDEADBEEF; #1;
    check("bypass r7 data", 64'(port_data(0)), 64'hDEADBEEF);
    check("bypass r7 busy", 64'(bus.rd_busy[0]), 64'h0);
    step(); idle(); #1;
    check("stored r7 data", 64'(port_data(0)), 64'hDEADBEEF);
    bus.we = 1; bus.waddr = 0; bus.wdata = 32'h1234; set_port(0, 0); #1;
    check("r0 write bypass ignored", 64'(port_data(0)), 64'h0);
    step(); idle(); #1;
    check("r0 still zero", 64'(port_data(0)), 64'h0);
    check("r0 write no underflow", 64'(bus.err_underflow), 64'h0);

    // Scoreboard on r3.
    set_port(0, 3); bus.issue_valid = 1; bus.issue_addr = 3; #1;
    check("same-cycle issue not busy", 64'(bus.rd_busy[0]), 64'h0);
    step(); #1;
    check("r3 busy after 1st issue", 64'(bus.rd_busy[0]), 64'h1);
    step(); idle(); bus.we = 1; bus.waddr = 3; bus.wdata = 32'h1111_1111; #1;
    check("r3 busy on 1st write", 64'(bus.rd_busy[0]), 64'h1);
    step(); bus.wdata = 32'h2222_2222; #1;
    check("r3 free on 2nd write", 64'(bus.rd_busy[0]), 64'h0);
    check("r3 bypass 2nd write", 64'(port_data(0)), 64'h2222_2222);
    step(); idle(); #1;
    check("r3 free after", 64'(bus.rd_busy[0]), 64'h0);

    // Simultaneous issue + write.
    set_port(0, 9); bus.issue_valid = 1; bus.issue_addr = 9;
    step(); bus.we = 1; bus.waddr = 9; bus.wdata = 32'h99; #1;
    check("r9 inc+dec cnt1 bypass not busy", 64'(bus.rd_busy[0]), 64'h0);
    step(); idle(); #1;
    check("r9 still busy cnt1", 64'(bus.rd_busy[0]), 64'h1);
    set_port(0, 11); bus.issue_valid = 1; bus.issue_addr = 11;
    bus.we = 1; bus.waddr = 11; bus.wdata = 32'hBB;
    step(); idle(); #1;
    check("r11 inc+dec cnt0 no underflow", 64'(bus.err_underflow), 64'h0);
    check("r11 not busy", 64'(bus.rd_busy[0]), 64'h0);

    // Saturation on r4.
    set_port(0, 4); bus.issue_valid = 1; bus.issue_addr = 4;
    step(); step(); step(); #1;
    check("r4 three issues no overflow", 64'(bus.err_overflow), 64'h0);
    step(); idle(); #1;
    check("r4 fourth issue overflow", 64'(bus.err_overflow), 64'h1);
    check("r4 busy", 64'(bus.rd_busy[0]), 64'h1);
    set_port(0, 10); bus.we = 1; bus.waddr = 10; bus.wdata = 32'hA5A5; #1;
    check("r10 bypass", 64'(port_data(0)), 64'hA5A5);
    step(); idle(); #1;
    check("r10 underflow", 64'(bus.err_underflow), 64'h1);
    check("r10 data written", 64'(port_data(0)), 64'hA5A5);

    // Flush with concurrent issue and write.
    bus.issue_valid = 1; bus.issue_addr = 2; step(); step();
    bus.issue_addr = 6; step();
    idle();
    for (int i = 0; i < NUM_RD; i++) set_port(i, 2);
    bus.flush = 1; bus.issue_valid = 1; bus.issue_addr = 2;
    bus.we = 1; bus.waddr = 6; bus.wdata = 32'h66; #1;
    check("pre-flush r2 busy all ports", 64'(bus.rd_busy), 64'hF);
    step(); idle(); #1;
    check("post-flush r2 busy all ports", 64'(bus.rd_busy), 64'h0);
    set_port(1, 6); set_port(2, 4); set_port(3, 9); #1;
    check("post-flush r6 data", 64'(port_data(1)), 64'h66);
    check("post-flush busy r6/r4/r9", 64'(bus.rd_busy), 64'h0);
    check("flush keeps errs", 64'({bus.err_overflow, bus.err_underflow}), 64'h3);

    // Asynchronous reset in the middle of a write burst.
    set_port(0, 7); set_port(1, 3);
    bus.we = 1; bus.waddr = 5; bus.wdata = 32'h55; bus.issue_valid = 1; bus.issue_addr = 5;
    step(); bus.wdata = 32'h56; #2;
    reset = 1'b0; #1;
    check("async reset r7", 64'(port_data(0)), 64'h0);
    check("async reset r3", 64'(port_data(1)), 64'h0);
    check("async reset errs", 64'({bus.err_overflow, bus.err_underflow}), 64'h0);
    check("async reset busy", 64'(bus.rd_busy), 64'h0);
    idle();
    step(); step(); #2;
    reset = 1'b1;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
